seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//  Multiplexed 7-segment display driver for the board's 4-digit hex display.
//  Consumes the single-cycle scan strobe from the clock divider (clkout, e.g. 500 Hz).
//  Lights one digit per strobe, rotating through NDIG digits.
//  Shows a frame-coherent snapshot of CPU debug data (PC, register value, etc.).
// PARAMETERS
//  NDIG   4   number of digits scanned, legal 2..8; data width = 4*NDIG
// PORTS
//  clkin   in   1       system clock; all logic on posedge
//  rst     in   1       synchronous reset, active-high
//  tick    in   1       scan strobe; sampled every cycle, each high cycle = one advance
//  data    in   4*NDIG  hex digits, data[3:0] = digit 0 (rightmost)
//  dp_in   in   NDIG    decimal points, bit i = digit i, 1 = lit
//  an      out  NDIG    digit enables, active-low, at most one bit low
//  seg     out  7       {g,f,e,d,c,b,a}, active-low
//  dp      out  1       decimal point, active-low
// BEHAVIOUR
//  - One clock, synchronous active-high reset; no other clocks or async paths.
//  - Reset: an = all 1s, seg = 7'h7F, dp = 1 (display dark); idx = NDIG-1;
//    shadow data/dp = 0. Outputs stay dark until the first tick after reset.
//  - idx: digit counter, $clog2(NDIG) bits. On a tick cycle: idx <= (idx==NDIG-1) ? 0 : idx+1.
//    No tick: all state holds.
//  - Frame snapshot: on the tick that wraps idx to 0, latch data/dp_in into shadow regs
//    on the same edge. Digits 1..NDIG-1 of that frame show shadow values.
//  - Digit 0 decodes the live data/dp_in on that edge (bypass), so a whole frame is coherent.
//  - Outputs are registered: an/seg/dp are loaded on the tick edge from next idx.
//    Visible 1 cycle after tick goes high; no combinational path from input to output.
//  - an: only bit[next idx] low. seg from the hex LUT (active-low):
//    0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//    A=08 b=03 C=46 d=21 E=06 F=0E (hex)
//  - dp = ~dp_bit[next idx].
//  - Boundaries:
//    - Tick held high N cycles advances N digits.
//    - data changing mid-frame: no effect until the next wrap.
//    - rst together with tick: reset wins.
//    - rst mid-frame: display dark immediately on the next edge.
// CONFIGURATION
//  - LZB_EN defined: leading-zero blanking.
//    - When the digit is loaded, digit i (i>=1) is blanked (seg = 7'h7F) if it and every
//      higher digit of the frame snapshot are 0.
//    - an is still driven low for that digit; dp is unaffected.
//    - Digit 0 is never blanked.
//  - LZB_EN undefined: every digit always shows its hex value.
// TESTING
//  1. rst=1 for 3 cycles, tick=0 -> an=4'hF, seg=7'h7F, dp=1; still dark 20 cycles after rst drops.
//  2. data=16'h12AF, dp_in=0, tick 1-cycle pulse every 10 clocks
//     -> successive (an,seg) = (E,0E), (D,08), (B,24), (7,79), then (E,0E) again.
//  3. Coherence: data=16'h1234; after the digit-0 tick set data=16'h5678
//     -> digits 1..3 show 3,2,1; next frame shows 8,7,6,5.
//  4. tick held high 3 consecutive cycles from idx=3 -> idx 0,1,2 on successive edges;
//     an ends at 4'hB.
//  5. dp_in=4'b0100 -> dp=0 only while an=4'hB; rst asserted together with tick -> outputs dark,
//     idx=NDIG-1.
//  6. LZB_EN, data=16'h0050 -> digit 3 seg=7F, digit 2 seg=7F, digit 1 seg=12, digit 0 seg=40;
//     without LZB_EN digits 3 and 2 show 40.

Source files
------------

// File: rtl/seg7_scan.sv
// Multiplexed hex display driver: one digit lit per scan strobe, frame-coherent snapshot.
// Optional leading-zero blanking when the LZB_EN macro is defined.
module seg7_scan #(
    parameter int NDIG = 4
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              tick,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp_in,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [6:0] SEG_DARK = 7'h7F;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_data_q, shadow_data_d;
    logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              wrap;
    logic [IDX_W-1:0]  nxt_idx;
    logic [3:0]        digit_val;
    logic              digit_dp;
    logic              digit_blank;
    logic [NDIG-1:0]   blank_mask;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] pick_nibble(input logic [4*NDIG-1:0] word,
                                               input logic [IDX_W-1:0] sel);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel == IDX_W'(i)) r = word[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic pick_bit(input logic [NDIG-1:0] vec,
                                      input logic [IDX_W-1:0] sel);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel == IDX_W'(i)) r = vec[i];
        end
        return r;
    endfunction

    // Bit i set when digit i and every digit above it in the word are zero; digit 0 never set.
    function automatic logic [NDIG-1:0] lead_zero_mask(input logic [4*NDIG-1:0] word);
        logic [NDIG-1:0] m;
        m = '0;
        m[NDIG-1] = (word[4*(NDIG-1) +: 4] == 4'h0);
        for (int i = NDIG - 2; i >= 1; i--) begin
            m[i] = m[i+1] & (word[4*i +: 4] == 4'h0);
        end
        m[0] = 1'b0;
        return m;
    endfunction

`ifdef LZB_EN
    assign blank_mask = lead_zero_mask(shadow_data_q);
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        idx_d         = idx_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_d          = dp_q;

        wrap    = (idx_q == LAST_IDX);
        nxt_idx = wrap ? '0 : idx_q + IDX_W'(1);

        // Digit 0 bypasses the shadow so it shows the same data the shadow captures now.
        digit_val   = wrap ? data[3:0] : pick_nibble(shadow_data_q, nxt_idx);
        digit_dp    = wrap ? dp_in[0]  : pick_bit(shadow_dp_q, nxt_idx);
        digit_blank = pick_bit(blank_mask, nxt_idx);

        if (tick) begin
            idx_d = nxt_idx;
            if (wrap) begin
                shadow_data_d = data;
                shadow_dp_d   = dp_in;
            end
            an_d  = ~(NDIG'(1) << nxt_idx);
            seg_d = digit_blank ? SEG_DARK : hex_to_seg(digit_val);
            dp_d  = ~digit_dp;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            idx_q         <= LAST_IDX;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            an_q          <= '1;
            seg_q         <= SEG_DARK;
            dp_q          <= 1'b1;
        end else begin
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (NDIG=4); expectations follow LZB_EN when it is defined.
module tb_seg7_scan;

    localparam int NDIG = 4;

    logic              clkin = 1'b0;
    logic              rst;
    logic              tick;
    logic [4*NDIG-1:0] data;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   an;
    logic [6:0]        seg;
    logic              dp;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];

    int          m_idx;
    logic [15:0] m_sh;
    logic [3:0]  m_dp_sh;

    seg7_scan #(.NDIG(NDIG)) dut (
        .clkin (clkin),
        .rst   (rst),
        .tick  (tick),
        .data  (data),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clkin = ~clkin;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic model_reset();
        m_idx   = NDIG - 1;
        m_sh    = '0;
        m_dp_sh = '0;
    endtask

    task automatic model_tick();
        int n;
        logic [3:0] v;
        logic d;
        logic [6:0] s;
        logic [3:0] a;
        n = (m_idx == NDIG - 1) ? 0 : m_idx + 1;
        if (n == 0) begin
            m_sh    = data;
            m_dp_sh = dp_in;
            v = data[3:0];
            d = dp_in[0];
        end else begin
            v = m_sh[4*n +: 4];
            d = m_dp_sh[n];
        end
        s = ref_seg(v);
`ifdef LZB_EN
        if (n >= 1 && (m_sh >> (4*n)) == 16'h0) s = 7'h7F;
`endif
        a = 4'hF;
        a[n] = 1'b0;
        exp_q.push_back({a, s, ~d});
        m_idx = n;
    endtask

    task automatic clk_edge();
        @(posedge clkin);
        #1;
    endtask

    task automatic drive_tick();
        tick = 1'b1;
        model_tick();
        clk_edge();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; data = '0; dp_in = '0;
        repeat (3) clk_edge();
        model_reset();
        total++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_dark got=%h want=%h", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        repeat (20) clk_edge();
        total++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_idle_dark got=%h want=%h", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        end
    endtask

    task automatic test_scan();
        logic [11:0] want [5];
        logic [11:0] w;
        want[0] = {4'hE, 7'h0E, 1'b1};
        want[1] = {4'hD, 7'h08, 1'b1};
        want[2] = {4'hB, 7'h24, 1'b1};
        want[3] = {4'h7, 7'h79, 1'b1};
        want[4] = {4'hE, 7'h0E, 1'b1};
        data = 16'h12AF; dp_in = '0;
        for (int k = 0; k < 5; k++) begin
            drive_tick();
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL scan_sb%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
            total++;
            if ({an, seg, dp} !== want[k]) begin
                bad++;
                $display("FAIL scan_const%0d got=%h want=%h", k, {an, seg, dp}, want[k]);
            end
            repeat (9) clk_edge();
            total++;
            if ({an, seg, dp} !== want[k]) begin
                bad++;
                $display("FAIL scan_hold%0d got=%h want=%h", k, {an, seg, dp}, want[k]);
            end
        end
    endtask

    task automatic test_coherence();
        logic [6:0]  want_seg [8];
        logic [11:0] w;
        want_seg = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00, 7'h78, 7'h02, 7'h12};
        for (int k = 0; k < 3; k++) begin
            drive_tick();
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL coh_lead%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
        end
        data = 16'h1234;
        for (int k = 0; k < 8; k++) begin
            drive_tick();
            if (k == 0) data = 16'h5678;
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL coh_sb%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
            total++;
            if (seg !== want_seg[k]) begin
                bad++;
                $display("FAIL coh_seg%0d got=%h want=%h", k, seg, want_seg[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w;
        tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model_tick();
            clk_edge();
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL burst_sb%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
        end
        tick = 1'b0;
        total++;
        if (an !== 4'hB) begin
            bad++;
            $display("FAIL burst_end_an got=%h want=%h", an, 4'hB);
        end
    endtask

    task automatic test_dp_and_reset();
        logic [11:0] w;
        dp_in = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            drive_tick();
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL dp_sb%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
            total++;
            if ((dp === 1'b0) !== (an === 4'hB)) begin
                bad++;
                $display("FAIL dp_pos%0d got dp=%b an=%h want dp low only at an=b", k, dp, an);
            end
        end
        rst = 1'b1; tick = 1'b1;
        clk_edge();
        rst = 1'b0; tick = 1'b0;
        model_reset();
        total++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL rst_tick_dark got=%h want=%h", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        end
        dp_in = '0;
        drive_tick();
        w = exp_q.pop_front();
        total++;
        if ({an, seg, dp} !== w) begin
            bad++;
            $display("FAIL rst_next_sb got=%h want=%h", {an, seg, dp}, w);
        end
        total++;
        if (an !== 4'hE) begin
            bad++;
            $display("FAIL rst_next_an got=%h want=%h", an, 4'hE);
        end
    endtask

    task automatic test_lzb();
        logic [6:0]  want_seg [4];
        logic [3:0]  want_an  [4];
        logic [11:0] w;
`ifdef LZB_EN
        want_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
        want_seg = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
        want_an = '{4'hE, 4'hD, 4'hB, 4'h7};
        data = 16'h0050; dp_in = '0;
        for (int k = 0; k < 3; k++) begin
            drive_tick();
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL lzb_lead%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive_tick();
            w = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== w) begin
                bad++;
                $display("FAIL lzb_sb%0d got=%h want=%h", k, {an, seg, dp}, w);
            end
            total++;
            if ({an, seg} !== {want_an[k], want_seg[k]}) begin
                bad++;
                $display("FAIL lzb_const%0d got=%h want=%h", k, {an, seg}, {want_an[k], want_seg[k]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; data = '0; dp_in = '0;
        model_reset();
        test_reset();
        test_scan();
        test_coherence();
        test_back_to_back();
        test_dp_and_reset();
        test_lzb();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
